nqueen_solver: RTL and testbench

//  Self-contained N-queens backtracking engine: controller FSM plus board datapath in one block.

---
 rtl/nqueen_pkg.sv | 22 ++
 rtl/nqueen_solver_if.sv | 28 ++
 rtl/nqueen_conflict_check.sv | 23 ++
 rtl/nqueen_solver.sv | 158 +++++++++++++++
 tb/tb_nqueen_solver.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nqueen_pkg.sv
// Shared definitions for the N-queens backtracking engine: FSM state codes,
// board-size limit and the row/column index width helper.
package nqueen_pkg;

  localparam int MAX_N = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PLACE     = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_ADVANCE   = 3'd3;
  localparam logic [2:0] S_ACCEPT    = 3'd4;
  localparam logic [2:0] S_BACKTRACK = 3'd5;
  localparam logic [2:0] S_EMIT      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nqueen_solver_if.sv
// Board-bus bundle for the N-queens engine: command/status handshake plus the
// solution beat stream (valid/ready, one row per beat).
interface nqueen_solver_if
  import nqueen_pkg::*;
#(
  parameter int W = idx_w(8)
) ();
  logic         start;
  logic         find_all;
  logic         abort;
  logic         busy;
  logic         done;
  logic         sol_valid;
  logic         sol_ready;
  logic [W-1:0] sol_row;
  logic [W-1:0] sol_col;
  logic         sol_last;

  modport master (
    input  start, find_all, abort, sol_ready,
    output busy, done, sol_valid, sol_row, sol_col, sol_last
  );

  modport slave (
    output start, find_all, abort, sol_ready,
    input  busy, done, sol_valid, sol_row, sol_col, sol_last
  );
endinterface

// File: rtl/nqueen_conflict_check.sv
// Combinational attack test of the candidate queen (row r, column c) against
// the queen already placed in row k at column col_k.
module nqueen_conflict_check
  import nqueen_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] c,
  input  logic [W-1:0] k,
  input  logic [W-1:0] col_k,
  output logic         conflict
);
  logic [W:0] dr;
  logic [W:0] dc;

  // One extra bit keeps the unsigned distances from wrapping.
  always_comb begin
    dr       = (r >= k)     ? ({1'b0, r} - {1'b0, k})     : ({1'b0, k} - {1'b0, r});
    dc       = (c >= col_k) ? ({1'b0, c} - {1'b0, col_k}) : ({1'b0, col_k} - {1'b0, c});
    conflict = (col_k == c) || (dr == dc);
  end
endmodule

// File: rtl/nqueen_solver.sv
// N-queens backtracking engine: controller FSM, col[] board and beat streamer.
// Optional macro NQ_STATS_EN adds the sol_count / cyc_count statistics ports.
module nqueen_solver
  import nqueen_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = idx_w(N),
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  nqueen_solver_if.master     bus
`ifdef NQ_STATS_EN
  ,
  output logic [CNT_W-1:0]    sol_count,
  output logic [31:0]         cyc_count
`endif
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state;
  logic [W-1:0] col [N];
  logic [W-1:0] r;
  logic [W-1:0] c;
  logic [W-1:0] k;
  logic [W-1:0] beat;
  logic         all_mode;
  logic         done_q;
  logic         conflict;
  logic         busy_w;
  logic         emit_w;

  nqueen_conflict_check #(.W(W)) u_check (
    .r        (r),
    .c        (c),
    .k        (k),
    .col_k    (col[k]),
    .conflict (conflict)
  );

  assign busy_w = (state != S_IDLE) && (state != S_DONE);
  assign emit_w = (state == S_EMIT);

  assign bus.busy      = busy_w;
  assign bus.done      = done_q;
  assign bus.sol_valid = emit_w;
  assign bus.sol_row   = emit_w ? beat : '0;
  assign bus.sol_col   = emit_w ? col[beat] : '0;
  assign bus.sol_last  = emit_w && (beat == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      r        <= '0;
      c        <= '0;
      k        <= '0;
      beat     <= '0;
      all_mode <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N; i++) col[i] <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort outranks everything, including a start in the same cycle.
      if (bus.abort) begin
        if (busy_w) state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state    <= S_PLACE;
              r        <= '0;
              c        <= '0;
              all_mode <= bus.find_all;
            end
          end
          S_PLACE: begin
            if (r == '0) begin
              state <= S_ACCEPT;
            end else begin
              k     <= r - W'(1);
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (conflict)      state <= S_ADVANCE;
            else if (k == '0)  state <= S_ACCEPT;
            else               k     <= k - W'(1);
          end
          S_ADVANCE: begin
            if (c != LAST) begin
              c     <= c + W'(1);
              state <= S_PLACE;
            end else begin
              state <= S_BACKTRACK;
            end
          end
          S_ACCEPT: begin
            col[r] <= c;
            if (r == LAST) begin
              beat  <= '0;
              state <= S_EMIT;
            end else begin
              r     <= r + W'(1);
              c     <= '0;
              state <= S_PLACE;
            end
          end
          S_BACKTRACK: begin
            if (r == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              r     <= r - W'(1);
              c     <= col[r - W'(1)];
              state <= S_ADVANCE;
            end
          end
          S_EMIT: begin
            if (bus.sol_ready) begin
              if (beat != LAST) begin
                beat <= beat + W'(1);
              end else if (all_mode) begin
                // r and c still hold the last row's queen, so resume from it.
                state <= S_ADVANCE;
              end else begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef NQ_STATS_EN
  logic sol_fire;
  logic start_acc;

  assign sol_fire  = emit_w && bus.sol_ready && (beat == LAST) && !bus.abort;
  assign start_acc = !busy_w && bus.start && !bus.abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sol_count <= '0;
      cyc_count <= '0;
    end else if (start_acc) begin
      sol_count <= '0;
      cyc_count <= '0;
    end else begin
      if (busy_w && (cyc_count != '1)) cyc_count <= cyc_count + 32'd1;
      if (sol_fire && (sol_count != '1)) sol_count <= sol_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nqueen_solver.sv
// Bench for nqueen_solver: six engines (N=1,3,4,6,8,8) checked against a
// software backtracker that fills per-engine expected-beat queues.
module tb_nqueen_solver;
  import nqueen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] rn, st, fa, ab, rdy;
  logic [5:0] vld, lst, bsy, dn;
  logic [3:0] rowv [6];
  logic [3:0] colv [6];
`ifdef NQ_STATS_EN
  logic [15:0] scnt [6];
  logic [31:0] ccnt [6];
`endif

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int NN = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 6 : 8;
    nqueen_solver_if #(.W(idx_w(NN))) bus ();
    nqueen_solver #(.N(NN)) dut (
      .clk   (clk),
      .reset (rn[g]),
      .bus   (bus)
`ifdef NQ_STATS_EN
      ,
      .sol_count (scnt[g]),
      .cyc_count (ccnt[g])
`endif
    );
    assign bus.start     = st[g];
    assign bus.find_all  = fa[g];
    assign bus.abort     = ab[g];
    assign bus.sol_ready = rdy[g];
    assign vld[g]  = bus.sol_valid;
    assign lst[g]  = bus.sol_last;
    assign bsy[g]  = bus.busy;
    assign dn[g]   = bus.done;
    assign rowv[g] = 4'(bus.sol_row);
    assign colv[g] = 4'(bus.sol_col);
  end

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } beat_t;

  typedef struct {
    int inst;
    int n;
    bit all;
    bit stall;
    int nsol;
    int first [8];
  } vec_t;

  beat_t sbq [6][$];
  vec_t  vt [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit safe_at(input int cols [16], input int r);
    for (int kk = 0; kk < r; kk++) begin
      if (cols[kk] == cols[r]) return 1'b0;
      if ((cols[kk] > cols[r] ? cols[kk] - cols[r] : cols[r] - cols[kk]) == r - kk) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit solution_ok(input int cols [16], input int n);
    for (int a = 0; a < n; a++) begin
      if (cols[a] < 0 || cols[a] >= n) return 1'b0;
      if (!safe_at(cols, a)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference enumerator: lexicographic, row 0 most significant.
  task automatic model(input int i, input int n, input bit all);
    int    cols [16];
    int    r;
    beat_t e;
    sbq[i].delete();
    r = 0;
    cols[0] = 0;
    while (r >= 0) begin
      if (cols[r] >= n) begin
        r--;
        if (r >= 0) cols[r]++;
      end else if (!safe_at(cols, r)) begin
        cols[r]++;
      end else if (r == n - 1) begin
        for (int b = 0; b < n; b++) begin
          e.row  = 4'(b);
          e.col  = 4'(cols[b]);
          e.last = (b == n - 1);
          sbq[i].push_back(e);
        end
        if (!all) break;
        cols[r]++;
      end else begin
        r++;
        cols[r] = 0;
      end
    end
  endtask

  task automatic run_vec(input int t, input bit poke);
    int         i, n, got, busyc;
    bit         held, seen_done;
    logic [3:0] prow, pcol;
    int         cur [16];
    int         firstc [16];
    beat_t      e;
    i = vt[t].inst;
    n = vt[t].n;
    model(i, n, vt[t].all);
    got = 0; busyc = 0; held = 1'b0; seen_done = 1'b0; prow = '0; pcol = '0;
    for (int a = 0; a < 16; a++) begin cur[a] = -1; firstc[a] = -1; end
    @(negedge clk);
    st[i] = 1'b1;
    fa[i] = vt[t].all;
    @(negedge clk);
    st[i] = 1'b0;
    check($sformatf("busy_after_start_v%0d", t), 32'(bsy[i]), 32'd1);
    for (int cyc = 0; cyc < 150000; cyc++) begin
      if (poke && cyc == 40) begin st[i] = 1'b1; fa[i] = 1'b1; end
      else if (poke && cyc == 41) st[i] = 1'b0;
      rdy[i] = vt[t].stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bsy[i]) busyc++;
      if (held) check($sformatf("stall_hold_v%0d", t), 32'({vld[i], rowv[i], colv[i]}), 32'({1'b1, prow, pcol}));
      held = 1'b0;
      if (vld[i]) begin
        if (!rdy[i]) begin
          held = 1'b1;
          prow = rowv[i];
          pcol = colv[i];
        end else begin
          if (sbq[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat_v%0d: got row %0d col %0d, required no beat", t, rowv[i], colv[i]);
          end else begin
            e = sbq[i].pop_front();
            check($sformatf("beat_v%0d", t), 32'({rowv[i], colv[i], lst[i]}), 32'({e.row, e.col, e.last}));
          end
          cur[rowv[i]] = int'(colv[i]);
          if (lst[i]) begin
            check($sformatf("ref_checker_v%0d", t), 32'(solution_ok(cur, n)), 32'd1);
            if (got == 0) firstc = cur;
            got++;
          end
        end
      end
      if (dn[i]) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen_done) begin
      total++;
      bad++;
      $display("FAIL timeout_v%0d: done never seen, required within budget", t);
    end
    check($sformatf("sol_total_v%0d", t), 32'(got), 32'(vt[t].nsol));
    check($sformatf("sb_empty_v%0d", t), 32'(sbq[i].size()), 32'd0);
    if (vt[t].nsol > 0)
      for (int a = 0; a < n; a++)
        check($sformatf("first_sol_v%0d_row%0d", t, a), 32'(firstc[a]), 32'(vt[t].first[a]));
`ifdef NQ_STATS_EN
    check($sformatf("sol_count_v%0d", t), 32'(scnt[i]), 32'(vt[t].nsol));
    check($sformatf("cyc_count_v%0d", t), ccnt[i], 32'(busyc));
`endif
    @(negedge clk);
    check($sformatf("done_pulse_len_v%0d", t), 32'(dn[i]), 32'd0);
    check($sformatf("idle_busy_v%0d", t), 32'(bsy[i]), 32'd0);
    rdy[i] = 1'b1;
  endtask

  initial begin
    bit found;
    int nd;
    rn = '0; st = '0; fa = '0; ab = '0; rdy = '1;
    vt[0] = '{0, 1, 1'b0, 1'b0, 1,  '{0, 0, 0, 0, 0, 0, 0, 0}};
    vt[1] = '{1, 3, 1'b1, 1'b0, 0,  '{0, 0, 0, 0, 0, 0, 0, 0}};
    vt[2] = '{2, 4, 1'b1, 1'b0, 2,  '{1, 3, 0, 2, 0, 0, 0, 0}};
    vt[3] = '{3, 6, 1'b1, 1'b1, 4,  '{1, 3, 5, 0, 2, 4, 0, 0}};
    vt[4] = '{4, 8, 1'b1, 1'b0, 92, '{0, 4, 7, 5, 2, 6, 1, 3}};
    vt[5] = '{5, 8, 1'b0, 1'b0, 1,  '{0, 4, 7, 5, 2, 6, 1, 3}};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++)
      check($sformatf("reset_outputs_%0d", i),
            32'({bsy[i], dn[i], vld[i], lst[i], rowv[i], colv[i]}), 32'd0);
    rn = '1;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      check($sformatf("post_reset_idle_%0d", i), 32'({bsy[i], dn[i], vld[i]}), 32'd0);

    for (int t = 0; t < 5; t++) begin
      automatic int tt = t;
      fork
        run_vec(tt, 1'b0);
      join_none
    end

    // Engine 5 (N=8): find-first, then multi-cycle corner sequences.
    run_vec(5, 1'b0);

    @(negedge clk);
    st[5] = 1'b1; fa[5] = 1'b0;
    @(negedge clk);
    st[5] = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 2000; w++) begin
      if (g_dut[5].dut.state == S_CHECK) begin found = 1'b1; break; end
      @(negedge clk);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL abort_setup: CHECK state not reached, required within 2000 cycles");
    end
    ab[5] = 1'b1;
    @(negedge clk);
    ab[5] = 1'b0;
    check("abort_busy", 32'(bsy[5]), 32'd0);
    check("abort_done", 32'(dn[5]), 32'd0);
    check("abort_valid", 32'(vld[5]), 32'd0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (dn[5] || bsy[5]) nd++;
    end
    check("abort_quiet", 32'(nd), 32'd0);

    st[5] = 1'b1; ab[5] = 1'b1;
    @(negedge clk);
    st[5] = 1'b0; ab[5] = 1'b0;
    check("abort_beats_start", 32'(bsy[5]), 32'd0);

    run_vec(5, 1'b1);

    rdy[5] = 1'b0;
    @(negedge clk);
    st[5] = 1'b1; fa[5] = 1'b0;
    @(negedge clk);
    st[5] = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 10000; w++) begin
      if (vld[5]) begin found = 1'b1; break; end
      @(negedge clk);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL emit_setup: sol_valid not seen, required within 10000 cycles");
    end
    check("emit_beat0", 32'({vld[5], rowv[5], colv[5]}), 32'({1'b1, 4'd0, 4'd0}));
    rdy[5] = 1'b1;
    @(negedge clk);
    rdy[5] = 1'b0;
    check("emit_beat1", 32'({vld[5], rowv[5], colv[5]}), 32'({1'b1, 4'd1, 4'd4}));
    repeat (3) @(negedge clk);
    check("emit_beat1_held", 32'({vld[5], rowv[5], colv[5]}), 32'({1'b1, 4'd1, 4'd4}));
    #2 rn[5] = 1'b0;
    #1 check("reset_mid_emit", 32'({bsy[5], dn[5], vld[5], lst[5], rowv[5], colv[5]}), 32'd0);
    @(negedge clk);
    rn[5] = 1'b1;
    rdy[5] = 1'b1;
    run_vec(5, 1'b0);

    wait fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
